// File: rtl/core_pkg.sv
// Shared register-file definitions for the pipelined core:
// default geometry, the hardwired-zero register index and common typedefs.
package core_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned NREG     = 32;
  localparam int unsigned AW       = $clog2(NREG);
  localparam int unsigned REG_ZERO = 0;

  typedef logic [AW-1:0]   regaddr_t;
  typedef logic [XLEN-1:0] xword_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits with set-over-clear priority, the outstanding-write
// count, and busy masking for writebacks that resolve in the current cycle.
module regfile_scoreboard
  import core_pkg::*;
#(
  parameter int unsigned NREG = core_pkg::NREG,
  parameter int unsigned AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] src_one,
  input  logic [AW-1:0] src_two,
  input  logic [AW-1:0] dest,
  input  logic          write_enable,
  input  logic          issue_valid,
  input  logic [AW-1:0] issue_rd,
  output logic          busy_one,
  output logic          busy_two,
  output logic [AW:0]   pending_cnt
);

  logic [NREG-1:1] busy;
  logic [NREG-1:1] busy_nxt;
  logic [NREG-1:0] busy_all;
  logic            set;
  logic            clr;
  logic            inc;
  logic            dec;

  assign set      = issue_valid && (issue_rd != AW'(REG_ZERO));
  assign clr      = write_enable && (dest != AW'(REG_ZERO));
  assign busy_all = {busy, 1'b0};

  // An issue to the register being retired re-arms it, so set wins over clear.
  always_comb begin
    busy_nxt = busy;
    for (int r = 1; r < NREG; r++) begin
      if (set && (issue_rd == AW'(r))) begin
        busy_nxt[r] = 1'b1;
      end else if (clr && (dest == AW'(r))) begin
        busy_nxt[r] = 1'b0;
      end else begin
        busy_nxt[r] = busy[r];
      end
    end
  end

  assign inc = set && !busy_all[issue_rd];
  assign dec = clr && busy_all[dest] && !(set && (issue_rd == dest));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy        <= '0;
      pending_cnt <= '0;
    end else begin
      busy        <= busy_nxt;
      pending_cnt <= pending_cnt + (AW+1)'(inc) - (AW+1)'(dec);
    end
  end

  // A same-cycle writeback supplies its data through the bypass, so no stall.
  assign busy_one = busy_all[src_one] && !(clr && (dest == src_one));
  assign busy_two = busy_all[src_two] && !(clr && (dest == src_two));

endmodule

// File: rtl/regfile_sb.sv
// Integer register file for the ID stage: x0 hardwired to zero, two
// combinational read ports with writeback bypass, plus a RAW-hazard scoreboard.
module regfile_sb
  import core_pkg::*;
#(
  parameter int unsigned XLEN = core_pkg::XLEN,
  parameter int unsigned NREG = core_pkg::NREG,
  parameter int unsigned AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   src_one,
  input  logic [AW-1:0]   src_two,
  output logic [XLEN-1:0] out_one,
  output logic [XLEN-1:0] out_two,
  output logic            busy_one,
  output logic            busy_two,
  input  logic [AW-1:0]   dest,
  input  logic            write_enable,
  input  logic [XLEN-1:0] data_in,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  output logic [AW:0]     pending_cnt
);

  logic [XLEN-1:0] regs [NREG-1:1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 1; r < NREG; r++) begin
        regs[r] <= '0;
      end
    end else if (write_enable && (dest != AW'(REG_ZERO))) begin
      regs[dest] <= data_in;
    end
  end

  always_comb begin
    if (src_one == AW'(REG_ZERO)) begin
      out_one = '0;
    end else if (write_enable && (dest == src_one)) begin
      out_one = data_in;
    end else begin
      out_one = regs[src_one];
    end
  end

  always_comb begin
    if (src_two == AW'(REG_ZERO)) begin
      out_two = '0;
    end else if (write_enable && (dest == src_two)) begin
      out_two = data_in;
    end else begin
      out_two = regs[src_two];
    end
  end

  regfile_scoreboard #(
    .NREG (NREG),
    .AW   (AW)
  ) u_scoreboard (
    .clk          (clk),
    .reset        (reset),
    .src_one      (src_one),
    .src_two      (src_two),
    .dest         (dest),
    .write_enable (write_enable),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .busy_one     (busy_one),
    .busy_two     (busy_two),
    .pending_cnt  (pending_cnt)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: a reference model produces expected
// values into a queue as stimulus is driven; they are popped when sampled.
module tb_regfile_sb;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic            clk;
  logic            reset;
  logic [AW-1:0]   src_one;
  logic [AW-1:0]   src_two;
  logic [XLEN-1:0] out_one;
  logic [XLEN-1:0] out_two;
  logic            busy_one;
  logic            busy_two;
  logic [AW-1:0]   dest;
  logic            write_enable;
  logic [XLEN-1:0] data_in;
  logic            issue_valid;
  logic [AW-1:0]   issue_rd;
  logic [AW:0]     pending_cnt;

  int checks = 0;
  int errors = 0;

  logic [XLEN-1:0] exp_q[$];
  logic [XLEN-1:0] exp;

  logic [XLEN-1:0] m_regs [NREG];
  logic            m_busy [NREG];

  regfile_sb #(.XLEN(XLEN), .NREG(NREG)) dut (
    .clk          (clk),
    .reset        (reset),
    .src_one      (src_one),
    .src_two      (src_two),
    .out_one      (out_one),
    .out_two      (out_two),
    .busy_one     (busy_one),
    .busy_two     (busy_two),
    .dest         (dest),
    .write_enable (write_enable),
    .data_in      (data_in),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .pending_cnt  (pending_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [XLEN-1:0] m_read(input logic [AW-1:0] a);
    if (a == 5'd0) return 32'd0;
    if (write_enable && dest == a) return data_in;
    return m_regs[a];
  endfunction

  function automatic logic m_busy_rd(input logic [AW-1:0] a);
    return m_busy[a] && !(write_enable && dest != 5'd0 && dest == a);
  endfunction

  function automatic logic [AW:0] m_count();
    logic [AW:0] c;
    c = '0;
    for (int r = 0; r < NREG; r++) c = c + {5'd0, m_busy[r]};
    return c;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NREG; r++) begin
      m_regs[r] = 32'd0;
      m_busy[r] = 1'b0;
    end
  endtask

  // Advance the model with the inputs present at the edge, then clock the DUT.
  task automatic step();
    if (write_enable && dest != 5'd0) begin
      m_regs[dest] = data_in;
      m_busy[dest] = 1'b0;
    end
    if (issue_valid && issue_rd != 5'd0) m_busy[issue_rd] = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    write_enable = 1'b0;
    issue_valid  = 1'b0;
    dest         = 5'd0;
    issue_rd     = 5'd0;
    data_in      = 32'd0;
  endtask

  // Push read-port expectations, settle, then pop and compare each.
  task automatic check_reads(input string tag);
    exp_q.push_back(m_read(src_one));
    exp_q.push_back(m_read(src_two));
    exp_q.push_back({31'd0, m_busy_rd(src_one)});
    exp_q.push_back({31'd0, m_busy_rd(src_two)});
    #1;
    exp = exp_q.pop_front(); checks++;
    if (out_one !== exp) begin errors++; $display("FAIL %s out_one: got %h, required %h", tag, out_one, exp); end
    exp = exp_q.pop_front(); checks++;
    if (out_two !== exp) begin errors++; $display("FAIL %s out_two: got %h, required %h", tag, out_two, exp); end
    exp = exp_q.pop_front(); checks++;
    if (busy_one !== exp[0]) begin errors++; $display("FAIL %s busy_one: got %b, required %b", tag, busy_one, exp[0]); end
    exp = exp_q.pop_front(); checks++;
    if (busy_two !== exp[0]) begin errors++; $display("FAIL %s busy_two: got %b, required %b", tag, busy_two, exp[0]); end
  endtask

  task automatic check_count(input string tag, input logic [AW:0] required);
    exp_q.push_back({26'd0, required});
    exp = exp_q.pop_front(); checks++;
    if (pending_cnt !== exp[AW:0]) begin
      errors++;
      $display("FAIL %s pending_cnt: got %0d, required %0d", tag, pending_cnt, exp[AW:0]);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    src_one = 5'd5;
    src_two = 5'd0;
    model_reset();
    #12;
    check_reads("reset_held");
    check_count("reset_held", 6'd0);
    #10;
    reset = 1'b1;
    @(posedge clk); #1;
    check_reads("after_reset");
    check_count("after_reset", 6'd0);
  endtask

  task automatic test_bypass();
    dest = 5'd3; write_enable = 1'b1; data_in = 32'hDEADBEEF;
    src_one = 5'd3; src_two = 5'd4;
    check_reads("bypass_same_cycle");
    step();
    idle_inputs();
    check_reads("bypass_next_cycle");
    exp_q.push_back(32'hDEADBEEF);
    exp = exp_q.pop_front(); checks++;
    if (out_one !== exp) begin errors++; $display("FAIL reg3_value out_one: got %h, required %h", out_one, exp); end
  endtask

  task automatic test_x0();
    dest = 5'd0; write_enable = 1'b1; data_in = 32'hFFFFFFFF;
    src_one = 5'd0; src_two = 5'd3;
    check_reads("x0_write_cycle");
    step();
    idle_inputs();
    check_reads("x0_after_write");
    issue_valid = 1'b1; issue_rd = 5'd0;
    step();
    idle_inputs();
    check_count("x0_issue", 6'd0);
  endtask

  task automatic test_busy();
    issue_valid = 1'b1; issue_rd = 5'd7; src_one = 5'd7; src_two = 5'd0;
    check_reads("issue7_same_cycle");
    step();
    idle_inputs();
    check_reads("issue7_next");
    check_count("issue7_next", m_count());
    check_count("issue7_is_one", 6'd1);
    write_enable = 1'b1; dest = 5'd7; data_in = 32'h0000_1234;
    check_reads("wb7_resolve");
    step();
    idle_inputs();
    check_reads("wb7_after");
    check_count("wb7_after", 6'd0);
  endtask

  task automatic test_set_clr_same();
    issue_valid = 1'b1; issue_rd = 5'd9;
    step();
    check_count("issue9", 6'd1);
    write_enable = 1'b1; dest = 5'd9; data_in = 32'h0909_0909;
    src_one = 5'd9; src_two = 5'd4;
    check_reads("set_clr_same_cycle");
    step();
    idle_inputs();
    check_reads("set_clr_same_after");
    check_count("set_clr_same", 6'd1);
    issue_valid = 1'b1; issue_rd = 5'd4;
    write_enable = 1'b1; dest = 5'd9; data_in = 32'h9999_0000;
    step();
    idle_inputs();
    src_one = 5'd4; src_two = 5'd9;
    check_reads("set_clr_diff");
    check_count("set_clr_diff", 6'd1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      write_enable = 1'($urandom_range(0, 1));
      issue_valid  = 1'($urandom_range(0, 1));
      dest         = 5'($urandom_range(0, NREG - 1));
      issue_rd     = 5'($urandom_range(0, NREG - 1));
      data_in      = $urandom;
      src_one      = ($urandom_range(0, 3) == 0) ? dest : 5'($urandom_range(0, NREG - 1));
      src_two      = 5'($urandom_range(0, NREG - 1));
      check_reads("random");
      step();
      check_count("random", m_count());
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    for (int r = 1; r < NREG; r++) begin
      issue_valid = 1'b1;
      issue_rd    = 5'(r);
      step();
      check_count("b2b", m_count());
    end
    idle_inputs();
    check_count("b2b_full", 6'd31);
    src_one = 5'd5; src_two = 5'd31;
    check_reads("b2b_busy");
  endtask

  task automatic test_async_reset();
    src_one = 5'd3; src_two = 5'd31;
    #3;
    reset = 1'b0;
    model_reset();
    check_reads("async_reset");
    check_count("async_reset", 6'd0);
    #10;
    reset = 1'b1;
    @(posedge clk); #1;
    check_reads("post_async_reset");
    check_count("post_async_reset", 6'd0);
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_x0();
    test_busy();
    test_set_clr_same();
    test_random();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised integer register file for the pipelined core; successor to the fixed 32x32, two-read/one-write file used in the single-cycle ID stage.
- Adds:
  - x0 hardwired to zero
  - same-cycle write-to-read bypass
  - a per-register scoreboard (busy bits) so ID can detect RAW hazards against in-flight writebacks
  - an outstanding-write counter
- Sits in ID; writeback drives the write port, issue logic drives the busy-set port.

Parameters:
- XLEN, 32, data width in bits.
- NREG, 32, number of architectural registers; power of two, >= 2.
- AW, $clog2(NREG), register address width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- src_one  in  AW  read port 1 address.
- src_two  in  AW  read port 2 address.
- out_one  out  XLEN  read port 1 data.
- out_two  out  XLEN  read port 2 data.
- busy_one  out  1  src_one has a pending write that is not resolved this cycle.
- busy_two  out  1  same for src_two.
- dest  in  AW  write address (writeback).
- write_enable  in  1  commit data_in to dest; also clears busy[dest].
- data_in  in  XLEN  write data.
- issue_valid  in  1  an instruction writing issue_rd is issued this cycle.
- issue_rd  in  AW  destination register of the issuing instruction.
- pending_cnt  out  AW+1  number of registers currently busy.

Behaviour:
- Reset (reset low, asynchronous):
  - All registers go to 0 and all busy bits clear.
  - pending_cnt = 0.
  - Outputs become 0 / not busy while reset is held, given reset values of the state.
  - Reset asserted mid-operation discards all pending state immediately.
- Storage:
  - NREG x XLEN registers written on the rising clk edge when write_enable=1 and dest!=0.
  - Register 0 has no storage and always reads 0.
- Reads are combinational, with zero latency:
  - out_x = 0 if src_x==0.
  - Otherwise out_x = data_in if write_enable and dest==src_x (bypass).
  - Otherwise out_x = reg[src_x].
- Scoreboard:
  - busy[NREG-1:1] are flops; busy[0] is constant 0.
  - On a clk edge, with set = issue_valid && issue_rd!=0 and clr = write_enable && dest!=0:
    - set on r: busy[r] <= 1.
    - clr on r: busy[r] <= 0.
    - set and clr on the same r in the same cycle: set wins, so busy stays 1 (old write retires, new write issued).
    - set and clr on different registers: both apply.
    - set on an already-busy r: busy stays 1; one bit per register, no multiple-outstanding tracking (issue logic must not issue a second writer to a busy rd).
    - clr on a non-busy r: no effect on busy or the count.
- Busy outputs:
  - busy_x = busy[src_x] && !(clr && dest==src_x).
  - A writeback resolving in the same cycle is reported not busy because its data is bypassed.
  - issue_valid in the current cycle does not affect busy_x until the next cycle.
- pending_cnt:
  - Registered; equals the popcount of busy[] after each edge.
  - Maintained incrementally: +1 if set hits a non-busy r; -1 if clr hits a busy r that is not simultaneously set.
  - Net 0 when both apply to the same r.
  - Maximum is NREG-1, so it never wraps.
- Writes with dest==0 and issues with issue_rd==0 are silently ignored: no data change, no busy change.

Decomposition:
- Shared package core_pkg: XLEN default, NREG default, the REG_ZERO constant (0), and the regaddr_t / xword_t typedefs.
- One natural sub-module, regfile_scoreboard: busy flops, set/clr priority, pending_cnt, busy_x masking.
- The data array and the bypass muxes stay in the top.

Test Plan:
- Reset, then read src_one=5, src_two=0 -> out_one=0, out_two=0, busy_one=busy_two=0, pending_cnt=0.
- Write dest=3, data_in=0xDEADBEEF, with src_one=3 in the same cycle -> out_one=0xDEADBEEF combinationally. Next cycle with write_enable=0 -> still 0xDEADBEEF.
- Write dest=0, data_in=0xFFFFFFFF -> src_one=0 reads 0. issue_rd=0 -> pending_cnt stays 0.
- Issue rd=7 -> next cycle busy_one=1 (src_one=7), pending_cnt=1. Writeback dest=7 with src_one=7 -> busy_one=0 in that cycle and out_one=data_in; after the edge pending_cnt=0.
- Same cycle issue_rd=9 and write dest=9, with 9 already busy -> busy[9] stays 1, pending_cnt unchanged. Issue rd=4 plus write dest=9 -> pending_cnt unchanged, busy[4]=1, busy[9]=0.
- Issue rd=1..31 on consecutive cycles -> pending_cnt=31 with no wrap. Assert reset low asynchronously between clock edges -> pending_cnt=0, all busy=0 and all registers 0 immediately.
